// File: rtl/riscv_timer_tickgen.sv
// APB-programmable tick source for the machine timer: internal divider or synchronised external NRZ.
// Optional external path enabled by defining RISCV_TIMER_TICKGEN_EXT_SRC_EN.
module riscv_timer_tickgen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        tick_in,
    output logic        tick
);

    localparam logic [15:0] AddrCtrl   = 16'h0000;
    localparam logic [15:0] AddrDiv    = 16'h0004;
    localparam logic [15:0] AddrCount  = 16'h0008;
    localparam logic [15:0] AddrStatus = 16'h000C;

    logic             bus_wr;
    logic             wr_ctrl, wr_div, wr_status;
    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             src;
    logic             ext_edge;
    logic             ext_seen;
    logic             unused_in;

    assign bus_wr    = psel && penable && pwrite;
    assign wr_ctrl   = bus_wr && (paddr == AddrCtrl);
    assign wr_div    = bus_wr && (paddr == AddrDiv);
    assign wr_status = bus_wr && (paddr == AddrStatus);

    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign tick    = tick_q;

`ifdef RISCV_TIMER_TICKGEN_EXT_SRC_EN
    logic src_q;
    logic s1_q, s2_q, s3_q;
    logic ext_seen_q, ext_seen_d;

    // Sync chain runs regardless of EN/SRC so EXT_SEEN always observes edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            ext_seen_q <= 1'b0;
        end else begin
            if (wr_ctrl) src_q <= pwdata[1];
            s1_q       <= tick_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            ext_seen_q <= ext_seen_d;
        end
    end

    assign ext_edge = s2_q ^ s3_q;
    // A new edge outranks a simultaneous write-1-to-clear.
    assign ext_seen_d = (ext_seen_q && !(wr_status && pwdata[0])) || ext_edge;
    assign src        = src_q;
    assign ext_seen   = ext_seen_q;
    assign unused_in  = ^pwdata;
`else
    assign ext_edge  = 1'b0;
    assign src       = 1'b0;
    assign ext_seen  = 1'b0;
    assign unused_in = ^{pwdata, tick_in, wr_status};
`endif

    always_comb begin
        en_d   = en_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;

        if (wr_ctrl) en_d = pwdata[0];
        if (wr_div)  div_d = pwdata[DIV_W-1:0];

        // Register writes reload the counter and suppress the tick for that cycle.
        if (wr_div) begin
            cnt_d = pwdata[DIV_W-1:0];
        end else if (wr_ctrl) begin
            cnt_d = div_q;
        end else if (en_q && !src) begin
            if (cnt_q <= DIV_W'(1)) begin
                tick_d = 1'b1;
                cnt_d  = div_q;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end else begin
            cnt_d = div_q;
        end

        if (!wr_ctrl && !wr_div && en_q && src) tick_d = ext_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            div_q  <= DIV_W'(1);
            cnt_q  <= DIV_W'(1);
            tick_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        prdata = 32'd0;
        case (paddr)
            AddrCtrl:   prdata = {30'd0, src, en_q};
            AddrDiv:    prdata = 32'(div_q);
            AddrCount:  prdata = 32'(cnt_q);
            AddrStatus: prdata = {31'd0, ext_seen};
            default:    prdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_riscv_timer_tickgen.sv
// Directed self-checking bench for riscv_timer_tickgen; external-source checks follow
// RISCV_TIMER_TICKGEN_EXT_SRC_EN.
module tb_riscv_timer_tickgen;

    logic        clk;
    logic        rst_n;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tick_in;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;

    riscv_timer_tickgen #(.DIV_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tick_in (tick_in),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge just after the write's commit edge.
    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        @(negedge clk);
        paddr = a;
        #1;
        check(tag, prdata, exp);
    endtask

    logic [15:0] cnt_exp [12] = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
    logic        tk_exp  [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic        seen;

    initial begin
        rst_n = 1'b0; paddr = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0; tick_in = 0;
        #23;
        check("tick_in_reset", {31'd0, tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rd_check("rst_ctrl", 16'h0000, 32'd0);
        rd_check("rst_div", 16'h0004, 32'd1);
        rd_check("rst_count", 16'h0008, 32'd1);
        rd_check("rst_status", 16'h000C, 32'd0);
        rd_check("rst_unmapped", 16'h0010, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("pready_pslverr", {30'd0, pready, pslverr}, 32'd2);

        // Divider, N = 4
        apb_write(16'h0004, 32'd4);
        rd_check("div_rd", 16'h0004, 32'd4);
        apb_write(16'h0000, 32'd1);
        paddr = 16'h0008;
        #1;
        check("div4_count_e", prdata, 32'd4);
        check("div4_tick_e", {31'd0, tick}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("div4_tick_%0d", i + 1), {31'd0, tick}, {31'd0, tk_exp[i]});
            check($sformatf("div4_count_%0d", i + 1), prdata, {16'd0, cnt_exp[i]});
        end

        // DIV = 0 gives a tick every cycle, then DIV = 3 mid-run
        apb_write(16'h0004, 32'd0);
        check("div0_write_cycle", {31'd0, tick}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("div0_tick_%0d", i), {31'd0, tick}, 32'd1);
        end
        apb_write(16'h0004, 32'd3);
        check("div3_write_cycle", {31'd0, tick}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("div3_tick_%0d", i), {31'd0, tick}, (i % 3 == 0) ? 32'd1 : 32'd0);
        end

`ifdef RISCV_TIMER_TICKGEN_EXT_SRC_EN
        apb_write(16'h0000, 32'd3);
        rd_check("ext_ctrl_rd", 16'h0000, 32'd3);
        rd_check("ext_seen_pre", 16'h000C, 32'd0);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            tick_in = ~tick_in;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                check($sformatf("ext_tick_t%0d_%0d", t, i), {31'd0, tick},
                      (i == 3) ? 32'd1 : 32'd0);
            end
        end
        rd_check("ext_seen_set", 16'h000C, 32'd1);
        apb_write(16'h000C, 32'd1);
        rd_check("ext_seen_w1c", 16'h000C, 32'd0);
`else
        apb_write(16'h0000, 32'd3);
        rd_check("nosrc_ctrl_rd", 16'h0000, 32'd1);
        tick_in = ~tick_in;
        repeat (6) @(negedge clk);
        rd_check("nosrc_status", 16'h000C, 32'd0);
`endif

        // SRC = 0: external edges produce no tick but still mark EXT_SEEN
        apb_write(16'h0004, 32'd1000);
        apb_write(16'h0000, 32'd1);
        tick_in = ~tick_in;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | tick;
        end
        check("src0_no_ext_tick", {31'd0, seen}, 32'd0);
`ifdef RISCV_TIMER_TICKGEN_EXT_SRC_EN
        rd_check("src0_ext_seen", 16'h000C, 32'd1);
`else
        rd_check("src0_ext_seen", 16'h000C, 32'd0);
`endif

        // EN = 0 silences the tick even with DIV = 0 and a toggling reference
        apb_write(16'h0004, 32'd0);
        @(negedge clk);
        check("div0_again", {31'd0, tick}, 32'd1);
        apb_write(16'h0000, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 5 == 0) tick_in = ~tick_in;
            seen = seen | tick;
        end
        check("en0_silent", {31'd0, seen}, 32'd0);

        // Asynchronous reset while the tick is high
        apb_write(16'h0004, 32'd5);
        apb_write(16'h0000, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_pre_tick", {31'd0, tick}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tick_drop", {31'd0, tick}, 32'd0);
        rd_check("rst2_ctrl", 16'h0000, 32'd0);
        rd_check("rst2_div", 16'h0004, 32'd1);
        rd_check("rst2_count", 16'h0008, 32'd1);
        rd_check("rst2_status", 16'h000C, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | tick;
        end
        check("rst2_no_tick", {31'd0, seen}, 32'd0);
        rd_check("rst2_count_hold", 16'h0008, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
